// File: rtl/vermibus_router_pkg.sv
// Shared types and constants for the Vermibus data-bus router.
package vermibus_router_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } router_state_t;

    localparam int DEVICE_ID_MSB = 31;
    localparam int DEVICE_ID_LSB = 24;
    localparam int MAX_DEVICES   = 16;

endpackage

// File: rtl/vermibus_router_if.sv
// Bundle of the CPU dbus side (m_*) and the per-channel device side (s_*) of the router.
interface vermibus_router_if
    import vermibus_router_pkg::*;
#(
    parameter int NUM_DEVICES = 4
);
    logic                         m_valid;
    logic [31:0]                  m_address;
    logic [3:0]                   m_wstrobe;
    logic [31:0]                  m_wdata;
    logic [31:0]                  m_rdata;
    logic                         m_ready;
    logic                         m_irq;
    logic [NUM_DEVICES-1:0]       s_valid;
    logic [31:0]                  s_address;
    logic [3:0]                   s_wstrobe;
    logic [31:0]                  s_wdata;
    logic [NUM_DEVICES-1:0][31:0] s_rdata;
    logic [NUM_DEVICES-1:0]       s_ready;
    logic [NUM_DEVICES-1:0]       s_irq;

    // The router itself: slave to the CPU, driver of the device channels.
    modport slave (
        input  m_valid, m_address, m_wstrobe, m_wdata,
        output m_rdata, m_ready, m_irq,
        output s_valid, s_address, s_wstrobe, s_wdata,
        input  s_rdata, s_ready, s_irq
    );

    // The CPU plus devices surrounding the router.
    modport master (
        output m_valid, m_address, m_wstrobe, m_wdata,
        input  m_rdata, m_ready, m_irq,
        input  s_valid, s_address, s_wstrobe, s_wdata,
        output s_rdata, s_ready, s_irq
    );

endinterface

// File: rtl/vermibus_timeout_counter.sv
// Saturating wait-cycle counter for the router; expired flags TIMEOUT_CYCLES reached.
module vermibus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1'b1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear beats start beats run; holds at LIMIT instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (start) begin
            cnt_d = ONE;
        end else if (run && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/vermibus_router.sv
// Address-decoding router from one dbus master to NUM_DEVICES Vermibus channels.
// Optional per-channel transfer counters: define VERMIBUS_ROUTER_STATS_EN.
module vermibus_router
    import vermibus_router_pkg::*;
#(
    parameter int          NUM_DEVICES    = 4,
    parameter logic [7:0]  DEV_IDS [NUM_DEVICES] = '{8'h00, 8'h10, 8'h20, 8'h30},
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERROR_RDATA    = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset_n,
    vermibus_router_if.slave  bus,
    output logic              err_pending,
    output logic [31:0]       err_address,
    input  logic              err_clear
`ifdef VERMIBUS_ROUTER_STATS_EN
    ,
    output logic [31:0]       stats_count [NUM_DEVICES]
`endif
);
    localparam int IDX_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

    router_state_t          state_q;
    router_state_t          state_d;
    logic                   hit_found_s;
    logic [IDX_W-1:0]       hit_idx_s;
    logic                   sel_ready_s;
    logic [NUM_DEVICES-1:0] s_valid_s;
    logic                   m_ready_s;
    logic [31:0]            m_rdata_s;
    logic                   err_event_s;
    logic                   tc_start_s;
    logic                   tc_run_s;
    logic                   tc_clear_s;
    logic                   tc_expired_s;
    logic                   err_pending_q;
    logic                   err_pending_d;
    logic [31:0]            err_address_q;
    logic [31:0]            err_address_d;

    // Descending scan so the lowest matching channel index wins.
    always_comb begin
        hit_found_s = 1'b0;
        hit_idx_s   = '0;
        for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
            if (bus.m_address[DEVICE_ID_MSB:DEVICE_ID_LSB] == DEV_IDS[i]) begin
                hit_found_s = 1'b1;
                hit_idx_s   = IDX_W'(i);
            end else begin
                hit_found_s = hit_found_s;
            end
        end
    end

    assign sel_ready_s = hit_found_s ? bus.s_ready[hit_idx_s] : 1'b0;

    // Master/device response muxing; ABORT masks the device completely.
    always_comb begin
        s_valid_s   = '0;
        m_ready_s   = 1'b0;
        m_rdata_s   = 32'h0000_0000;
        err_event_s = 1'b0;
        if (state_q == ABORT) begin
            m_ready_s   = 1'b1;
            m_rdata_s   = ERROR_RDATA;
            err_event_s = 1'b1;
        end else if (bus.m_valid) begin
            if (hit_found_s) begin
                s_valid_s[hit_idx_s] = 1'b1;
                m_ready_s            = bus.s_ready[hit_idx_s];
                m_rdata_s            = bus.s_rdata[hit_idx_s];
            end else begin
                m_ready_s   = 1'b1;
                m_rdata_s   = ERROR_RDATA;
                err_event_s = 1'b1;
            end
        end else begin
            m_ready_s = 1'b0;
        end
    end

    // FSM next state and timeout counter controls.
    always_comb begin
        state_d    = state_q;
        tc_start_s = 1'b0;
        tc_run_s   = 1'b0;
        tc_clear_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.m_valid && hit_found_s && !sel_ready_s) begin
                    state_d    = WAIT;
                    tc_start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!bus.m_valid || sel_ready_s) begin
                    state_d    = IDLE;
                    tc_clear_s = 1'b1;
                end else if (tc_expired_s) begin
                    state_d    = ABORT;
                    tc_clear_s = 1'b1;
                end else begin
                    tc_run_s = 1'b1;
                end
            end
            ABORT: begin
                state_d    = IDLE;
                tc_clear_s = 1'b1;
            end
            default: begin
                state_d    = IDLE;
                tc_clear_s = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    vermibus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (tc_start_s),
        .run     (tc_run_s),
        .clear   (tc_clear_s),
        .expired (tc_expired_s)
    );

    // Sticky error: clear wins; only the first error address after a clear is kept.
    always_comb begin
        err_pending_d = err_pending_q;
        err_address_d = err_address_q;
        if (err_clear) begin
            err_pending_d = 1'b0;
        end else if (err_event_s && !err_pending_q) begin
            err_pending_d = 1'b1;
            err_address_d = bus.m_address;
        end else begin
            err_pending_d = err_pending_q;
        end
    end

    // Error capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_pending_q <= 1'b0;
            err_address_q <= 32'h0000_0000;
        end else begin
            err_pending_q <= err_pending_d;
            err_address_q <= err_address_d;
        end
    end

`ifdef VERMIBUS_ROUTER_STATS_EN
    logic [31:0] stats_q [NUM_DEVICES];

    // Per-channel completed-transfer counters, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DEVICES; i++) begin
                stats_q[i] <= 32'h0000_0000;
            end
        end else if (err_clear) begin
            for (int i = 0; i < NUM_DEVICES; i++) begin
                stats_q[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < NUM_DEVICES; i++) begin
                if (s_valid_s[i] && bus.s_ready[i] && (stats_q[i] != 32'hFFFF_FFFF)) begin
                    stats_q[i] <= stats_q[i] + 32'd1;
                end else begin
                    stats_q[i] <= stats_q[i];
                end
            end
        end
    end

    assign stats_count = stats_q;
`endif

    assign bus.s_valid   = s_valid_s;
    assign bus.s_address = bus.m_address;
    assign bus.s_wstrobe = bus.m_wstrobe;
    assign bus.s_wdata   = bus.m_wdata;
    assign bus.m_ready   = m_ready_s;
    assign bus.m_rdata   = m_rdata_s;
    assign bus.m_irq     = |bus.s_irq;
    assign err_pending   = err_pending_q;
    assign err_address   = err_address_q;

endmodule

// File: tb/tb_vermibus_router.sv
// Directed self-checking bench for vermibus_router (4 channels, 8-cycle timeout).
module tb_vermibus_router;
    import vermibus_router_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        err_pending;
    logic [31:0] err_address;
    logic        err_clear;
`ifdef VERMIBUS_ROUTER_STATS_EN
    logic [31:0] stats_count [4];
`endif

    int checks;
    int errors;

    vermibus_router_if #(.NUM_DEVICES(4)) bus ();

    vermibus_router #(
        .NUM_DEVICES    (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .err_pending (err_pending),
        .err_address (err_address),
        .err_clear   (err_clear)
`ifdef VERMIBUS_ROUTER_STATS_EN
        ,
        .stats_count (stats_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Single zero-wait transfer to the given address with the given ready vector.
    task automatic quick_xfer(input logic [31:0] addr, input logic [3:0] rdy);
        @(negedge clk);
        bus.m_valid   = 1'b1;
        bus.m_address = addr;
        bus.s_ready   = rdy;
        @(negedge clk);
        bus.m_valid   = 1'b0;
        bus.s_ready   = 4'b0000;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        err_clear     = 1'b0;
        bus.m_valid   = 1'b0;
        bus.m_address = 32'h0000_0000;
        bus.m_wstrobe = 4'b0000;
        bus.m_wdata   = 32'h0000_0000;
        bus.s_rdata   = '0;
        bus.s_ready   = 4'b0000;
        bus.s_irq     = 4'b0000;

        repeat (2) @(negedge clk);
        #1;
        check_val("rst_state",    32'(dut.state_q),   32'd0);
        check_val("rst_s_valid",  32'(bus.s_valid),   32'h0);
        check_val("rst_m_ready",  32'(bus.m_ready),   32'h0);
        check_val("rst_m_rdata",  bus.m_rdata,        32'h0);
        check_val("rst_err_pend", 32'(err_pending),   32'h0);
        check_val("rst_err_addr", err_address,        32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: zero-wait read from channel 1
        @(negedge clk);
        bus.m_valid    = 1'b1;
        bus.m_address  = 32'h1000_0004;
        bus.s_ready    = 4'b0010;
        bus.s_rdata[1] = 32'h1234_5678;
        #1;
        check_val("t1_m_ready", 32'(bus.m_ready), 32'h1);
        check_val("t1_m_rdata", bus.m_rdata,      32'h1234_5678);
        check_val("t1_s_valid", 32'(bus.s_valid), 32'h2);
        check_val("t1_s_addr",  bus.s_address,    32'h1000_0004);
        @(posedge clk);
        #1;
        check_val("t1_state", 32'(dut.state_q), 32'd0);
        @(negedge clk);
        bus.m_valid = 1'b0;
        bus.s_ready = 4'b0000;
        #1;
        check_val("idle_m_rdata", bus.m_rdata, 32'h0);

        // 2: write to channel 2, ready on the fourth cycle
        @(negedge clk);
        bus.m_valid   = 1'b1;
        bus.m_address = 32'h2000_0000;
        bus.m_wstrobe = 4'b0001;
        bus.m_wdata   = 32'hA5A5_A5A5;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 4) bus.s_ready = 4'b0100;
            #1;
            check_val($sformatf("t2_s_valid_c%0d", k), 32'(bus.s_valid), 32'h4);
            check_val($sformatf("t2_m_ready_c%0d", k), 32'(bus.m_ready), (k == 4) ? 32'h1 : 32'h0);
        end
        check_val("t2_s_wstrobe", 32'(bus.s_wstrobe), 32'h1);
        check_val("t2_s_wdata",   bus.s_wdata,        32'hA5A5_A5A5);
        @(negedge clk);
        bus.m_valid   = 1'b0;
        bus.s_ready   = 4'b0000;
        bus.m_wstrobe = 4'b0000;
        #1;
        check_val("t2_state",    32'(dut.state_q), 32'd0);
        check_val("t2_err_pend", 32'(err_pending), 32'h0);

        // 3: unmapped access
        @(negedge clk);
        bus.m_valid   = 1'b1;
        bus.m_address = 32'h7F00_0000;
        bus.s_ready   = 4'b1111;
        #1;
        check_val("t3_m_ready",  32'(bus.m_ready), 32'h1);
        check_val("t3_m_rdata",  bus.m_rdata,      32'hDEAD_BEEF);
        check_val("t3_s_valid",  32'(bus.s_valid), 32'h0);
        check_val("t3_err_pre",  32'(err_pending), 32'h0);
        @(negedge clk);
        bus.m_valid = 1'b0;
        bus.s_ready = 4'b0000;
        #1;
        check_val("t3_err_pend", 32'(err_pending), 32'h1);
        check_val("t3_err_addr", err_address,      32'h7F00_0000);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        #1;
        check_val("t3_err_clr", 32'(err_pending), 32'h0);

        // 4: channel 3 never ready -> 8 WAIT cycles then ABORT
        @(negedge clk);
        bus.m_valid   = 1'b1;
        bus.m_address = 32'h3000_0000;
        #1;
        check_val("t4_s_valid0", 32'(bus.s_valid), 32'h8);
        check_val("t4_m_ready0", 32'(bus.m_ready), 32'h0);
        for (int w = 1; w <= 8; w++) begin
            @(negedge clk);
            #1;
            check_val($sformatf("t4_state_w%0d", w), 32'(dut.state_q),           32'd1);
            check_val($sformatf("t4_cnt_w%0d", w),   32'(dut.u_timeout.cnt_q),   32'(w));
        end
        check_val("t4_m_ready_w8", 32'(bus.m_ready), 32'h0);
        @(negedge clk);
        bus.s_ready    = 4'b1000;
        bus.s_rdata[3] = 32'h5555_5555;
        #1;
        check_val("t4_abort_state", 32'(dut.state_q), 32'd2);
        check_val("t4_abort_ready", 32'(bus.m_ready), 32'h1);
        check_val("t4_abort_rdata", bus.m_rdata,      32'hDEAD_BEEF);
        check_val("t4_abort_valid", 32'(bus.s_valid), 32'h0);
        @(negedge clk);
        bus.m_valid = 1'b0;
        bus.s_ready = 4'b0000;
        #1;
        check_val("t4_state_end", 32'(dut.state_q), 32'd0);
        check_val("t4_err_pend",  32'(err_pending), 32'h1);
        check_val("t4_err_addr",  err_address,      32'h3000_0000);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;

        // 5: reset during WAIT, then a normal request
        @(negedge clk);
        bus.m_valid   = 1'b1;
        bus.m_address = 32'h0000_0010;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("t5_state_wait", 32'(dut.state_q), 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("t5_rst_state",   32'(dut.state_q),         32'd0);
        check_val("t5_rst_cnt",     32'(dut.u_timeout.cnt_q), 32'd0);
        check_val("t5_rst_m_ready", 32'(bus.m_ready),         32'h0);
        @(negedge clk);
        reset_n     = 1'b1;
        bus.m_valid = 1'b0;
        @(negedge clk);
        bus.m_valid    = 1'b1;
        bus.m_address  = 32'h0000_0020;
        bus.s_ready    = 4'b0001;
        bus.s_rdata[0] = 32'hCAFE_F00D;
        #1;
        check_val("t5_m_ready", 32'(bus.m_ready), 32'h1);
        check_val("t5_m_rdata", bus.m_rdata,      32'hCAFE_F00D);
        @(negedge clk);
        bus.m_valid = 1'b0;
        bus.s_ready = 4'b0000;
        #1;
        check_val("t5_state", 32'(dut.state_q), 32'd0);

        // interrupt OR
        bus.s_irq = 4'b0100;
        #1;
        check_val("irq_on", 32'(bus.m_irq), 32'h1);
        bus.s_irq = 4'b0000;
        #1;
        check_val("irq_off", 32'(bus.m_irq), 32'h0);

`ifdef VERMIBUS_ROUTER_STATS_EN
        // 6: transfer counters
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        for (int n = 0; n < 5; n++) quick_xfer(32'h0000_0000 + 32'(n * 4), 4'b0001);
        for (int n = 0; n < 2; n++) quick_xfer(32'h1000_0000, 4'b0010);
        #1;
        check_val("t6_stats0", stats_count[0], 32'd5);
        check_val("t6_stats1", stats_count[1], 32'd2);
        check_val("t6_stats2", stats_count[2], 32'd0);
        check_val("t6_stats3", stats_count[3], 32'd0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        #1;
        check_val("t6_clr0", stats_count[0], 32'd0);
        check_val("t6_clr1", stats_count[1], 32'd0);
`else
        quick_xfer(32'h0000_0000, 4'b0001);
        #1;
        check_val("nostats_state", 32'(dut.state_q), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
